instr_fetch: RTL and testbench

- Instruction-fetch (IF) stage of the pipelined MIPS datapath; the reader of the word-addressed, combinational-read instruction memory.
- Owns the PC and drives the memory word address from it. Latches the returned word into the IF/ID pipeline register.
- Handles stall, redirect (branch/jump from ID) and flush, and raises a fetch fault when the PC leaves the instruction-memory window.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_ifid.sv | 33 +++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
// Holds the reset PC, bubble word, fetch FSM encoding and IF/ID record.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef logic [1:0] state_t;

  localparam state_t BOOT = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t HALT = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/instr_fetch_ifid.sv
// IF/ID pipeline register with hold, bubble and load controls.
// Ports: clk, rst, hold, bubble, load, d (incoming record), q (latched).
module ifid_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = instr_fetch_pkg::NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  logic  load,
  input  ifid_t d,
  output ifid_t q
);

  // Bubble keeps pc4 so a held-then-squashed slot stays traceable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q.instr <= NOP_WORD;
      q.pc4   <= 32'd0;
      q.valid <= 1'b0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q.instr <= NOP_WORD;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, next-PC select, fetch FSM, fault detect.
// Ports: stall/flush/redirect controls, imem addr/data, IF/ID outputs.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = instr_fetch_pkg::RESET_PC,
  parameter int          IM_AWIDTH = 10,
  parameter logic [31:0] NOP_WORD  = instr_fetch_pkg::NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [IM_AWIDTH-1:0] im_addr,
  input  logic [31:0]          im_dout,
  output logic [31:0]          pc,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_pc4,
  output logic                 ifid_valid,
  output logic                 fetch_fault
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;
  logic [31:0] pc_inc;
  logic [31:0] pc_tgt;
  logic        tgt_bad;
  logic        fault_set;
  logic        hold;
  logic        bubble;
  logic        load;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  assign im_addr = pc[IM_AWIDTH+1:2];
  assign pc_inc  = pc + 32'd4;
  assign pc_tgt  = redirect ? redirect_pc : pc_inc;

  // Window is the 2^IM_AWIDTH-word region sharing RESET_PC's upper bits;
  // running off the top therefore faults instead of wrapping.
  assign tgt_bad =
    (pc_tgt[1:0] != 2'b00) ||
    (pc_tgt[31:IM_AWIDTH+2] != RESET_PC[31:IM_AWIDTH+2]);

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    fault_set = 1'b0;
    hold      = 1'b0;
    bubble    = 1'b0;
    load      = 1'b0;
    unique case (state)
      BOOT: begin
        hold     = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        unique case (1'b1)
          stall: begin
            hold   = ~flush;
            bubble = flush;
          end
          default: begin
            bubble = redirect | flush;
            load   = ~(redirect | flush);
            if (tgt_bad) begin
              fault_set = 1'b1;
              state_nx  = HALT;
            end else begin
              pc_nx = pc_tgt;
            end
          end
        endcase
      end
      HALT: begin
        hold   = stall;
        bubble = ~stall;
      end
      default: begin
        state_nx = HALT;
        bubble   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (fault_set) fetch_fault <= 1'b1;
    end
  end

  assign ifid_d.instr = im_dout;
  assign ifid_d.pc4   = pc_inc;
  assign ifid_d.valid = 1'b1;

  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .bubble (bubble),
    .load   (load),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational word memory.
// Memory word i holds 32'hC0DE_0000 + i.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign im_dout = mem[im_addr];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_addr     (im_addr),
    .im_dout     (im_dout),
    .pc          (pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fetch_fault (fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag,
                        input logic [31:0] epc,
                        input logic [31:0] einstr,
                        input logic [31:0] epc4,
                        input logic        evalid,
                        input logic        efault);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".instr"}, ifid_instr, einstr);
    chk({tag, ".pc4"}, ifid_pc4, epc4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, evalid});
    chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, efault});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;

    // reset state and BOOT
    do_reset();
    chk_if("rst", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst.im_addr", {22'd0, im_addr}, 32'd0);
    step();
    chk_if("boot", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);

    // free run W0..W3
    step();
    chk_if("w0", 32'h3004, 32'hC0DE_0000, 32'h3004, 1'b1, 1'b0);
    step();
    chk_if("w1", 32'h3008, 32'hC0DE_0001, 32'h3008, 1'b1, 1'b0);
    step();
    chk_if("w2", 32'h300C, 32'hC0DE_0002, 32'h300C, 1'b1, 1'b0);
    step();
    chk_if("w3", 32'h3010, 32'hC0DE_0003, 32'h3010, 1'b1, 1'b0);

    // stall for 3 cycles holding W1
    do_reset();
    step();
    step();
    step();
    chk_if("s.w1", 32'h3008, 32'hC0DE_0001, 32'h3008, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("stall", 32'h3008, 32'hC0DE_0001, 32'h3008, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_if("s.w2", 32'h300C, 32'hC0DE_0002, 32'h300C, 1'b1, 1'b0);

    // redirect from 0x3008 to 0x3040
    do_reset();
    step();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h3040;
    step();
    redirect = 1'b0;
    chk_if("rd.bub", 32'h3040, 32'h0, 32'h3008, 1'b0, 1'b0);
    step();
    chk_if("rd.tgt", 32'h3044, 32'hC0DE_0010, 32'h3044, 1'b1, 1'b0);

    // stall + flush + redirect together
    stall = 1'b1;
    flush = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h3080;
    step();
    stall = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    chk_if("sfr", 32'h3044, 32'h0, 32'h3044, 1'b0, 1'b0);
    step();
    chk_if("sfr.nx", 32'h3048, 32'hC0DE_0011, 32'h3048, 1'b1, 1'b0);

    // misaligned redirect faults
    redirect = 1'b1;
    redirect_pc = 32'h3002;
    step();
    redirect = 1'b0;
    chk_if("mis", 32'h3048, 32'h0, 32'h3048, 1'b0, 1'b1);
    step();
    chk_if("mis.halt", 32'h3048, 32'h0, 32'h3048, 1'b0, 1'b1);
    step();
    chk_if("mis.halt2", 32'h3048, 32'h0, 32'h3048, 1'b0, 1'b1);
    do_reset();
    chk_if("mis.rst", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // out-of-window redirect faults
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    step();
    redirect = 1'b0;
    chk_if("oow", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk_if("oow.halt", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b1);
    do_reset();
    chk_if("oow.rst", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);

    // free run off the top of the window
    step();
    redirect = 1'b1;
    redirect_pc = 32'h3FFC;
    step();
    redirect = 1'b0;
    chk_if("top.rd", 32'h3FFC, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk_if("top.flt", 32'h3FFC, 32'hC0DE_03FF, 32'h4000, 1'b1, 1'b1);
    step();
    chk_if("top.halt", 32'h3FFC, 32'h0, 32'h4000, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
